minv_reg_word_seq: RTL and testbench
====================================

Name: minv_reg_word_seq

Overview:
- Word sequencer directly upstream and downstream of the 256-bit U/T operand register in the modular-inverse datapath.
- Load: accepts operand words over a valid/ready stream and drives the register's 32-bit cyclic-write path.
- Unload: rotates the register 32 bits at a time and streams the result words out. After the rotation sequence the register holds its original value.
- Register control ports belong to this block only while `busy`=1. Outside that window the core's right-shift control drives the register through an external mux selected by `busy`.

Parameters:
- DW, 32, word width; must equal the register's write-port width.
- NWORDS, 8, words per operand; DW*NWORDS = 256.
- CW, 3, counter width, ceil(log2(NWORDS)).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_load  input  1  1-cycle pulse: start a load of NWORDS words.
- cmd_unload  input  1  1-cycle pulse: start an unload of NWORDS words.
- abort  input  1  synchronous abort of the current operation.
- in_valid  input  1  input word valid.
- in_ready  output  1  input word accepted when in_valid && in_ready.
- in_data  input  DW  input word; least-significant word first.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream ready.
- out_data  output  DW  output word; least-significant word first.
- reg_we  output  1  register write enable.
- reg_sel_cyc  output  1  0 = write reg_regin, 1 = rotate right 32 bits.
- reg_sel_rs  output  1  1-bit right-shift select; always 0 from this block.
- reg_regin  output  DW  data to the register write port.
- reg_regout_lo  input  DW  register bits [31:0].
- busy  output  1  high in LOAD or UNLOAD; selects this block as register controller.
- done  output  1  1-cycle pulse after the final word of an operation.

Behaviour:
- States: IDLE, LOAD, UNLOAD. Word counter `cnt` is CW bits wide.
- Reset (rst=1): next state IDLE, cnt=0. All outputs 0 after the reset edge: in_ready, out_valid, reg_we, reg_sel_cyc, reg_sel_rs, busy, done, reg_regin, out_data.
- IDLE
  - cmd_load → LOAD, cnt=0. cmd_unload → UNLOAD, cnt=0.
  - Both asserted in the same cycle: LOAD wins and cmd_unload is dropped.
  - in_ready=0, out_valid=0, reg_we=0.
- LOAD
  - in_ready=1. reg_sel_cyc=0. reg_regin=in_data, combinational.
  - reg_we = in_valid, so the register is written in the same cycle as the accept.
  - Each accept increments cnt. An accept with cnt=NWORDS-1 → IDLE, cnt=0, done=1 next cycle.
  - After NWORDS writes, word 0 sits in register bits [31:0].
- UNLOAD
  - out_valid=1. out_data=reg_regout_lo, combinational. reg_sel_cyc=1.
  - reg_we = out_ready, so the register rotates on each transfer.
  - The next word is presented the cycle after a transfer. Zero extra latency; with out_ready held high, one word per cycle.
  - A transfer with cnt=NWORDS-1 → IDLE, done=1. The register is then back to its pre-unload contents.
- Stalls: in_valid=0 or out_ready=0 holds state, cnt, and the register (reg_we=0). There is no timeout.
- Commands while busy: ignored, not queued.
- abort
  - In LOAD or UNLOAD: reg_we is forced 0 that cycle, in_ready=0, out_valid=0, next state IDLE, cnt=0, done is not asserted.
  - The register may be partially loaded or rotated; the issuer reloads it.
  - In IDLE: abort has no effect and takes priority over any command in the same cycle.
- rst mid-operation: behaves as abort. No further reg_we after the reset cycle.
- busy = (state != IDLE). reg_sel_rs is tied 0.
- done is registered, high exactly one cycle, and coincides with the first IDLE cycle.
- cnt wraps only via the terminal transition and never exceeds NWORDS-1.

Test Plan:
- Load with stream: cmd_load, then words 0x00000001..0x00000008 with in_valid=1 continuously → 8 consecutive reg_we with reg_sel_cyc=0; register = 0x00000008_..._00000001; done pulses 1 cycle after the 8th accept; busy high for exactly 8 cycles.
- Unload after that load, out_ready=1 → out_data 0x1,0x2,…,0x8 on consecutive cycles; 8 rotate writes; register afterwards equals the pre-unload value; done once.
- Backpressure: unload with out_ready toggling 1,0,0,1,… → no reg_we during stall cycles; out_data stable while stalled; sequence still 0x1..0x8.
- Input bubbles: in_valid low on cycles 2–4 of a load → reg_we only on valid cycles; load completes after 8 accepts; cnt unchanged during bubbles.
- Command collisions: cmd_load and cmd_unload together in IDLE → LOAD entered. cmd_unload during LOAD → ignored, no UNLOAD afterward. abort together with cmd_load in IDLE → stays IDLE.
- Abort/reset mid-op: abort after 3 accepted words → IDLE next cycle, no done, no further reg_we. A fresh load then completes 8 words correctly. rst asserted mid-unload → all outputs 0 after the edge.

Source files
------------

// File: rtl/minv_reg_word_seq_if.sv
// Stream interface for the U/T operand register word sequencer.
// Carries the operand load stream (in_*) and the result unload stream (out_*).
//   master : the side that produces in_* words and consumes out_* words
//   slave  : the sequencer itself
interface minv_reg_word_seq_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/minv_reg_word_seq.sv
// Word sequencer around the 256-bit U/T operand register.
// LOAD streams NWORDS words (LS word first) into the register's 32-bit
// cyclic-write port; UNLOAD rotates the register right one word per transfer
// and streams register bits [DW-1:0] out, so that after NWORDS transfers the
// register again holds its original value.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cmd_load/unload    1-cycle start pulses (load wins if both)
//   abort              synchronous abort of the current operation
//   strm               in_* / out_* valid-ready word streams
//   reg_we, reg_sel_cyc, reg_sel_rs, reg_regin
//                      register control, meaningful only while busy=1
//   reg_regout_lo      register bits [DW-1:0]
//   busy               high in LOAD or UNLOAD; selects this block on the mux
//   done               1-cycle pulse on the first IDLE cycle after completion
module minv_reg_word_seq #(
  parameter int DW     = 32,
  parameter int NWORDS = 8,
  parameter int CW     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_load,
  input  logic                cmd_unload,
  input  logic                abort,
  minv_reg_word_seq_if.slave  strm,
  output logic                reg_we,
  output logic                reg_sel_cyc,
  output logic                reg_sel_rs,
  output logic [DW-1:0]       reg_regin,
  input  logic [DW-1:0]       reg_regout_lo,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          done_reg;

  // A reset or abort cycle must not touch the register or complete a
  // handshake, so both squash the datapath strobes combinationally.
  logic active;
  logic in_load;
  logic in_unload;
  logic in_fire;
  logic out_fire;
  logic word_fire;

  assign active    = !(rst || abort);
  assign in_load   = (state_reg == LOAD);
  assign in_unload = (state_reg == UNLOAD);
  assign in_fire   = in_load && active && strm.in_valid;
  assign out_fire  = in_unload && active && strm.out_ready;
  assign word_fire = in_fire || out_fire;

  assign strm.in_ready  = in_load && active;
  assign strm.out_valid = in_unload && active;
  // Data paths are gated so every output reads 0 outside their state.
  assign strm.out_data  = in_unload ? reg_regout_lo : '0;
  assign reg_regin      = in_load ? strm.in_data : '0;
  assign reg_we         = word_fire;
  assign reg_sel_cyc    = in_unload;
  assign reg_sel_rs     = 1'b0;
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          // abort in IDLE only suppresses commands arriving with it
          if (!abort) begin
            if (cmd_load) begin
              state_reg <= LOAD;
              cnt_reg   <= '0;
            end else if (cmd_unload) begin
              state_reg <= UNLOAD;
              cnt_reg   <= '0;
            end
          end
        end
        LOAD, UNLOAD: begin
          if (abort) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (word_fire) begin
            if (cnt_reg == LAST) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
              done_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minv_reg_word_seq.sv
// Bench for minv_reg_word_seq: behavioural 256-bit U/T register model, directed
// load/unload sequences, and a queue scoreboard checked by a negedge monitor.
module tb_minv_reg_word_seq;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_load = 1'b0;
  logic          cmd_unload = 1'b0;
  logic          abort = 1'b0;
  logic          reg_we, reg_sel_cyc, reg_sel_rs, busy, done;
  logic [DW-1:0] reg_regin, reg_regout_lo;
  logic [255:0]  model = '0;

  minv_reg_word_seq_if #(.DW(DW)) sif ();

  minv_reg_word_seq #(.DW(DW), .NWORDS(8), .CW(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_load      (cmd_load),
    .cmd_unload    (cmd_unload),
    .abort         (abort),
    .strm          (sif.slave),
    .reg_we        (reg_we),
    .reg_sel_cyc   (reg_sel_cyc),
    .reg_sel_rs    (reg_sel_rs),
    .reg_regin     (reg_regin),
    .reg_regout_lo (reg_regout_lo),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Register: cyclic write shifts right one word inserting regin at the top;
  // rotate moves the low word to the top.
  always @(posedge clk)
    if (reg_we)
      model <= reg_sel_cyc ? {model[31:0], model[255:32]} : {reg_regin, model[255:32]};
  assign reg_regout_lo = model[31:0];

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0, done_cnt = 0, busy_cnt = 0;
  logic [31:0] exp_q[$];
  bit          stalled_prev = 1'b0;
  logic [31:0] held = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled at negedge, half a cycle away from the active edge.
  always @(negedge clk) begin
    we_cnt   += int'(reg_we);
    done_cnt += int'(done);
    busy_cnt += int'(busy);
    if (sif.out_valid && sif.out_ready) begin
      if (exp_q.size() == 0) check("out_unexpected", 256'(sif.out_data), 256'h1_0000_0000);
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("out_data", 256'(sif.out_data), 256'(e));
        $display("unload word %08h (expected %08h)", sif.out_data, e);
      end
    end
    if (sif.out_valid && stalled_prev) check("stall_hold", 256'(sif.out_data), 256'(held));
    if (sif.out_valid && !sif.out_ready) check("stall_we", 256'(reg_we), 256'(0));
    if (sif.in_ready && !sif.in_valid) check("bubble_we", 256'(reg_we), 256'(0));
    stalled_prev = sif.out_valid && !sif.out_ready;
    held = sif.out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // abort_after < 8 aborts on that word; both issues cmd_load+cmd_unload;
  // poke asserts cmd_unload alongside word 2.
  task automatic do_load(input logic [255:0] val, input int nbub, input bit poke,
                         input int abort_after, input bit both);
    int we0 = we_cnt, busy0 = busy_cnt, d0 = done_cnt;
    cmd_load = 1'b1; cmd_unload = both;
    tick();
    cmd_load = 1'b0; cmd_unload = 1'b0;
    check("load_enter_busy", 256'(busy), 256'(1));
    check("load_enter_rdy", 256'(sif.in_ready), 256'(1));
    for (int i = 0; i < 8; i++) begin
      if (i == 1) repeat (nbub) begin sif.in_valid = 1'b0; tick(); end
      if (i == abort_after) begin
        sif.in_valid = 1'b1; sif.in_data = val[32*i +: 32]; abort = 1'b1;
        #1;
        check("abort_we", 256'(reg_we), 256'(0));
        check("abort_rdy", 256'(sif.in_ready), 256'(0));
        tick();
        abort = 1'b0;
        check("abort_idle", 256'({busy, done}), 256'(0));
        repeat (3) tick();
        sif.in_valid = 1'b0;
        check("abort_no_we", 256'(we_cnt - we0), 256'(i));
        check("abort_no_done", 256'(done_cnt - d0), 256'(0));
        $display("load aborted after %0d words", i);
        return;
      end
      sif.in_valid = 1'b1; sif.in_data = val[32*i +: 32];
      cmd_unload = poke && (i == 2);
      #1;
      check("load_regin", 256'(reg_regin), 256'(val[32*i +: 32]));
      check("load_we_cyc", 256'({reg_we, reg_sel_cyc, reg_sel_rs}), 256'(3'b100));
      tick();
      cmd_unload = 1'b0;
    end
    sif.in_valid = 1'b0;
    check("load_done", 256'({done, busy}), 256'(2'b10));
    check("load_reg", model, val);
    tick();
    check("load_done_once", 256'({done, busy}), 256'(0));
    check("load_we_count", 256'(we_cnt - we0), 256'(8));
    check("load_busy_cycles", 256'(busy_cnt - busy0), 256'(8 + nbub));
    check("load_done_count", 256'(done_cnt - d0), 256'(1));
    $display("load %064h bubbles=%0d done", val, nbub);
  endtask

  // toggle: out_ready pattern 1,0,0,1,...; rst_after < 8 resets mid-unload.
  task automatic do_unload(input logic [255:0] val, input bit toggle, input int rst_after);
    int xfers = 0, cyc = 0, we0 = we_cnt, d0 = done_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(val[32*i +: 32]);
    cmd_unload = 1'b1;
    tick();
    cmd_unload = 1'b0;
    while (xfers < 8 && cyc < 40) begin
      if (xfers == rst_after) begin
        sif.out_ready = 1'b1; rst = 1'b1;
        #1;
        check("rst_cycle_we", 256'(reg_we), 256'(0));
        tick();
        rst = 1'b0;
        check("rst_outputs", 256'({sif.in_ready, sif.out_valid, reg_we, reg_sel_cyc, reg_sel_rs,
                                   busy, done, reg_regin, sif.out_data}), 256'(0));
        exp_q.delete();
        repeat (2) tick();
        check("rst_no_we", 256'(we_cnt - we0), 256'(xfers));
        sif.out_ready = 1'b0;
        $display("unload reset after %0d words", xfers);
        return;
      end
      sif.out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (sif.out_valid && sif.out_ready) xfers++;
      tick();
      cyc++;
    end
    sif.out_ready = 1'b0;
    if (cyc >= 40) check("unload_timeout", 256'(xfers), 256'(8));
    check("unload_done", 256'({done, busy}), 256'(2'b10));
    check("unload_reg_restored", model, val);
    tick();
    check("unload_q_empty", 256'(exp_q.size()), 256'(0));
    check("unload_we_count", 256'(we_cnt - we0), 256'(8));
    check("unload_done_count", 256'(done_cnt - d0), 256'(1));
    $display("unload %064h toggle=%0d cycles=%0d", val, toggle, cyc);
  endtask

  localparam logic [255:0] V1 =
    256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
  localparam logic [255:0] V2 =
    256'hF0F0F0F0_0F0F0F0F_CAFEF00D_80000001_00000000_FFFFFFFF_12345678_DEADBEEF;

  initial begin
    sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_outputs", 256'({sif.in_ready, sif.out_valid, reg_we, reg_sel_cyc, reg_sel_rs,
                                 busy, done, reg_regin, sif.out_data}), 256'(0));
    do_load(V1, 0, 1'b0, 8, 1'b0);
    do_unload(V1, 1'b0, 99);
    do_unload(V1, 1'b1, 99);
    do_load(V2, 3, 1'b0, 8, 1'b0);
    do_unload(V2, 1'b0, 99);
    do_load(V1, 0, 1'b1, 8, 1'b1);
    check("no_unload_after_poke", 256'(busy), 256'(0));
    cmd_load = 1'b1; abort = 1'b1;
    tick();
    cmd_load = 1'b0; abort = 1'b0;
    check("abort_beats_cmd", 256'({busy, sif.in_ready}), 256'(0));
    do_load(V2, 0, 1'b0, 3, 1'b0);
    do_load(V2, 0, 1'b0, 8, 1'b0);
    do_unload(V2, 1'b0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
